// File: rtl/seq_rca_adder_pkg.sv
// rca_pkg: FSM state type and default geometry for the chunked ripple-carry adder
package rca_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam int RCA_WIDTH = 16;
  localparam int RCA_CHUNK = 4;
endpackage

// File: rtl/seq_rca_adder_if.sv
// seq_rca_adder_if: operand/result handshake bus; Overflow exists only with SEQ_RCA_OVERFLOW_EN
interface seq_rca_adder_if import rca_pkg::*; #(parameter int WIDTH = RCA_WIDTH);
  logic             in_valid, in_ready, C, out_valid, out_ready, Carry;
  logic [WIDTH-1:0] A, B, S;
`ifdef SEQ_RCA_OVERFLOW_EN
  logic             Overflow;
`endif
  modport master(output in_valid, A, B, C, out_ready, input in_ready, out_valid, S, Carry
`ifdef SEQ_RCA_OVERFLOW_EN
    , Overflow
`endif
  );
  modport slave(input in_valid, A, B, C, out_ready, output in_ready, out_valid, S, Carry
`ifdef SEQ_RCA_OVERFLOW_EN
    , Overflow
`endif
  );
endinterface

// File: rtl/seq_rca_adder_chunk.sv
// rca_chunk: combinational CHUNK-bit ripple-carry slice, also exposing the carry into its MSB
module rca_chunk #(parameter int CHUNK = 4) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);
  logic carry;
  always_comb begin
    carry    = cin;
    c_msb_in = cin;
    s        = '0;
    for (int i = 0; i < CHUNK; i++) begin
      if (i == CHUNK - 1) c_msb_in = carry;
      s[i]  = a[i] ^ b[i] ^ carry;
      carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end
endmodule

// File: rtl/seq_rca_adder.sv
// seq_rca_adder: multi-cycle adder, one CHUNK-bit slice per cycle; signed Overflow under SEQ_RCA_OVERFLOW_EN
module seq_rca_adder import rca_pkg::*; #(
  parameter int WIDTH = RCA_WIDTH,
  parameter int CHUNK = RCA_CHUNK
) (
  input logic         clk,
  input logic         rst,
  seq_rca_adder_if.slave bus
);
  localparam int NCHUNK = (CHUNK > 0) ? WIDTH / CHUNK : 1;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  if (CHUNK <= 0 || WIDTH <= 0 || WIDTH % CHUNK != 0) begin : g_bad_width
    $error("seq_rca_adder: WIDTH must be a positive multiple of CHUNK");
  end
  state_t           state, state_n;
  logic [WIDTH-1:0] a_r, b_r, s_r;
  logic [KW-1:0]    k;
  logic             cy, cout, last;
  logic [CHUNK-1:0] sum;
`ifdef SEQ_RCA_OVERFLOW_EN
  logic             c_msb, ovf;
`endif
  assign last = k == KW'(NCHUNK - 1);
  rca_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a        (a_r[int'(k)*CHUNK +: CHUNK]),
    .b        (b_r[int'(k)*CHUNK +: CHUNK]),
    .cin      (cy),
    .s        (sum),
    .cout     (cout),
`ifdef SEQ_RCA_OVERFLOW_EN
    .c_msb_in (c_msb)
`else
    .c_msb_in ()
`endif
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_n;
  always_comb
    state_n = (state == IDLE) ? (bus.in_valid ? BUSY : IDLE) :
              (state == BUSY) ? (last ? DONE : BUSY) :
              (bus.out_ready ? IDLE : DONE);
  always_comb begin
    bus.in_ready  = state == IDLE;
    bus.out_valid = state == DONE;
  end
  // cy doubles as the visible Carry: after the last slice it holds the carry-out
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      a_r <= '0;
      b_r <= '0;
      s_r <= '0;
      cy  <= 1'b0;
      k   <= '0;
`ifdef SEQ_RCA_OVERFLOW_EN
      ovf <= 1'b0;
`endif
    end else if (state == IDLE && bus.in_valid) begin
      a_r <= bus.A;
      b_r <= bus.B;
      cy  <= bus.C;
      k   <= '0;
    end else if (state == BUSY) begin
      s_r[int'(k)*CHUNK +: CHUNK] <= sum;
      cy  <= cout;
      k   <= last ? '0 : k + 1'b1;
`ifdef SEQ_RCA_OVERFLOW_EN
      ovf <= cout ^ c_msb;
`endif
    end
  assign bus.S     = s_r;
  assign bus.Carry = cy;
`ifdef SEQ_RCA_OVERFLOW_EN
  assign bus.Overflow = ovf;
`endif
endmodule

// File: tb/tb_seq_rca_adder.sv
// tb_seq_rca_adder: directed checks of the 16/4 adder plus a sweep of an 8/8 instance
module tb_seq_rca_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  always #5 clk = ~clk;

  seq_rca_adder_if #(.WIDTH(16)) bus ();
  seq_rca_adder_if #(.WIDTH(8))  bus8 ();
  seq_rca_adder #(.WIDTH(16), .CHUNK(4)) dut  (.clk(clk), .rst(rst), .bus(bus));
  seq_rca_adder #(.WIDTH(8),  .CHUNK(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic c, output int lat);
    bus.A = a; bus.B = b; bus.C = c; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.S !== 16'h0 || bus.Carry !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: rdy=%b vld=%b S=%h C=%b required rdy=1 vld=0 S=0000 C=0",
               bus.in_ready, bus.out_valid, bus.S, bus.Carry);
    end
`ifdef SEQ_RCA_OVERFLOW_EN
    n_checks++;
    if (bus.Overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_overflow: got %b required 0", bus.Overflow);
    end
`endif
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus8.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_idle: rdy=%b vld=%b rdy8=%b required 1 0 1",
               bus.in_ready, bus.out_valid, bus8.in_ready);
    end
  endtask

  task automatic test_basic();
    int lat;
    start_op(16'h0000, 16'h0005, 1'b0, lat);
    n_checks++;
    if (lat !== 4) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d cycles required 4", lat);
    end
    n_checks++;
    if (bus.S !== 16'h0005 || bus.Carry !== 1'b0 || bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_sum: S=%h C=%b rdy=%b required S=0005 C=0 rdy=0", bus.S, bus.Carry, bus.in_ready);
    end
    drain();
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_drain: vld=%b rdy=%b required 0 1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_carry();
    int lat;
    start_op(16'hFFFF, 16'h0001, 1'b0, lat);
    n_checks++;
    if (lat !== 4 || bus.S !== 16'h0000 || bus.Carry !== 1'b1) begin
      n_fail++;
      $display("FAIL carry_out: lat=%0d S=%h C=%b required lat=4 S=0000 C=1", lat, bus.S, bus.Carry);
    end
    drain();
    start_op(16'h8000, 16'h8000, 1'b1, lat);
    n_checks++;
    if (bus.S !== 16'h0001 || bus.Carry !== 1'b1) begin
      n_fail++;
      $display("FAIL carry_msb_wrap: S=%h C=%b required S=0001 C=1", bus.S, bus.Carry);
    end
`ifdef SEQ_RCA_OVERFLOW_EN
    n_checks++;
    if (bus.Overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_neg: got %b required 1", bus.Overflow);
    end
`endif
    drain();
    start_op(16'h7FFF, 16'h0001, 1'b0, lat);
    n_checks++;
    if (bus.S !== 16'h8000 || bus.Carry !== 1'b0) begin
      n_fail++;
      $display("FAIL pos_wrap: S=%h C=%b required S=8000 C=0", bus.S, bus.Carry);
    end
`ifdef SEQ_RCA_OVERFLOW_EN
    n_checks++;
    if (bus.Overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_pos: got %b required 1", bus.Overflow);
    end
`endif
    drain();
  endtask

  task automatic test_hold();
    int lat;
    start_op(16'h1234, 16'h4321, 1'b0, lat);
    for (int i = 0; i < 5; i++) begin
      bus.A = ~bus.A; bus.B = bus.B + 16'h0101; bus.C = ~bus.C; bus.in_valid = 1'b1;
      @(negedge clk);
      n_checks++;
      if (bus.S !== 16'h5555 || bus.Carry !== 1'b0 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL hold_cycle%0d: S=%h C=%b rdy=%b vld=%b required S=5555 C=0 rdy=0 vld=1",
                 i, bus.S, bus.Carry, bus.in_ready, bus.out_valid);
      end
    end
    drain();
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_release: vld=%b rdy=%b required 0 1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset_busy();
    int lat;
    bool_vld_seen: begin end
    bus.A = 16'h0003; bus.B = 16'h0004; bus.C = 1'b1; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.S !== 16'h0 || bus.Carry !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_in_busy: rdy=%b vld=%b S=%h C=%b required rdy=1 vld=0 S=0000 C=0",
               bus.in_ready, bus.out_valid, bus.S, bus.Carry);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_no_valid%0d: vld=%b required 0", i, bus.out_valid);
      end
    end
    rst = 1'b0;
    start_op(16'h1234, 16'h1111, 1'b1, lat);
    n_checks++;
    if (lat !== 4 || bus.S !== 16'h2346 || bus.Carry !== 1'b0) begin
      n_fail++;
      $display("FAIL after_reset_op: lat=%0d S=%h C=%b required lat=4 S=2346 C=0", lat, bus.S, bus.Carry);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    logic [15:0] va [3] = '{16'h1111, 16'hABCD, 16'hFFFF};
    logic [15:0] vb [3] = '{16'h2222, 16'h1234, 16'hFFFF};
    logic        vc [3] = '{1'b0, 1'b1, 1'b1};
    logic [15:0] es [3] = '{16'h3333, 16'hBE02, 16'hFFFF};
    logic        ec [3] = '{1'b0, 1'b0, 1'b1};
    int idx = 0, got = 0, last_acc = 0;
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && got < 3; cyc++) begin
      if (bus.out_valid) begin
        n_checks++;
        if (bus.S !== es[got] || bus.Carry !== ec[got]) begin
          n_fail++;
          $display("FAIL b2b_result%0d: S=%h C=%b required S=%h C=%b", got, bus.S, bus.Carry, es[got], ec[got]);
        end
        got++;
      end
      if (bus.in_ready && idx < 3) begin
        if (idx > 0) begin
          n_checks++;
          if (cyc - last_acc !== 6) begin
            n_fail++;
            $display("FAIL b2b_period%0d: got %0d cycles required 6", idx, cyc - last_acc);
          end
        end
        last_acc = cyc;
        bus.A = va[idx]; bus.B = vb[idx]; bus.C = vc[idx]; bus.in_valid = 1'b1;
        idx++;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    n_checks++;
    if (got !== 3) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d results required 3", got);
    end
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_sweep8();
    logic [7:0] a, b;
    logic       c;
    logic [8:0] exp_sum;
    int         lat;
    for (int i = 0; i < 16; i++) begin
      a = (i == 0) ? 8'hFF : 8'($urandom_range(0, 255));
      b = (i == 0) ? 8'hFF : 8'($urandom_range(0, 255));
      c = (i == 0) ? 1'b1  : 1'($urandom_range(0, 1));
      exp_sum = 9'(a) + 9'(b) + 9'(c);
      bus8.A = a; bus8.B = b; bus8.C = c; bus8.in_valid = 1'b1;
      @(negedge clk);
      bus8.in_valid = 1'b0;
      lat = 0;
      while (!bus8.out_valid && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      n_checks++;
      if (lat !== 1 || {bus8.Carry, bus8.S} !== exp_sum) begin
        n_fail++;
        $display("FAIL sweep8_%0d: %h+%h+%b lat=%0d got %h required lat=1 sum=%h",
                 i, a, b, c, lat, {bus8.Carry, bus8.S}, exp_sum);
      end
      bus8.out_ready = 1'b1;
      @(negedge clk);
      bus8.out_ready = 1'b0;
    end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.A = '0; bus.B = '0; bus.C = 1'b0; bus.out_ready = 1'b0;
    bus8.in_valid = 1'b0; bus8.A = '0; bus8.B = '0; bus8.C = 1'b0; bus8.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_basic();
    test_carry();
    test_hold();
    test_reset_busy();
    test_back_to_back();
    test_sweep8();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/seq_rca_adder.md
SEQ_RCA_ADDER -- requirements
Module: seq_rca_adder

Interface
REQ-001 Parameter WIDTH, default 16: operand and sum width in bits.
REQ-002 Parameter CHUNK, default 4: bits added per clock cycle (ripple slice width).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  operands A, B, C presented.
REQ-006 in_ready  output  1  block can accept an operation.
REQ-007 A  input  WIDTH  operand A, unsigned.
REQ-008 B  input  WIDTH  operand B, unsigned.
REQ-009 C  input  1  carry-in.
REQ-010 out_valid  output  1  S, Carry (and Overflow) hold a completed result.
REQ-011 out_ready  input  1  consumer takes the result.
REQ-012 S  output  WIDTH  sum.
REQ-013 Carry  output  1  carry-out of bit WIDTH-1.
REQ-014 Overflow  output  1  signed overflow; present only when the macro in REQ-030 is defined.

Function
REQ-015 WIDTH SHALL be a positive multiple of CHUNK; any other value SHALL cause an elaboration error. NCHUNK = WIDTH/CHUNK.
REQ-016 FSM states SHALL be IDLE, BUSY, DONE.
REQ-017 IDLE: in_ready=1; on in_valid=1, SHALL register A, B, C, clear the chunk index, and go to BUSY.
REQ-018 BUSY: in_ready=0; each cycle SHALL add chunk k of the registered A and B plus the registered carry, write S[k*CHUNK +: CHUNK], update the carry register, and increment k.
REQ-019 After chunk NCHUNK-1 the FSM SHALL go to DONE. out_valid SHALL rise exactly NCHUNK cycles after the accept edge.
REQ-020 DONE: out_valid=1 and in_ready=0; S, Carry and Overflow SHALL hold stable until out_ready=1.
REQ-021 DONE with out_ready=1: SHALL go to IDLE on that edge. No new operation SHALL be accepted in the same cycle.
REQ-022 Changes on A, B, C or in_valid while in BUSY or DONE SHALL be ignored.
REQ-023 Result SHALL equal {Carry,S} = A + B + C, computed modulo 2^(WIDTH+1).
REQ-024 out_ready while out_valid=0 SHALL have no effect.
REQ-025 Minimum throughput SHALL be one operation per NCHUNK+2 cycles.

Reset
REQ-026 rst=1 SHALL immediately force state IDLE, in_ready=1, out_valid=0, S=0, Carry=0, Overflow=0, chunk index 0, and carry register 0.
REQ-027 Reset during BUSY or DONE SHALL abort the operation; no out_valid pulse SHALL follow.
REQ-028 On the first edge after rst deasserts, the block SHALL be able to accept an operation.

Configuration
REQ-029 A single macro SHALL control the Overflow output.
REQ-030 With SEQ_RCA_OVERFLOW_EN defined: port Overflow exists, equals the carry into bit WIDTH-1 XOR Carry, is valid with out_valid, and is held in DONE. Without the macro: the port and its logic are absent, and all other behaviour is identical.

Structure
REQ-031 Package rca_pkg SHALL hold the FSM state enum type and the default WIDTH and CHUNK constants.
REQ-032 Sub-module rca_chunk SHALL be a combinational CHUNK-bit ripple-carry adder (a, b, cin -> s, cout, c_msb_in), instantiated once and reused each BUSY cycle.

Verification
REQ-033 WIDTH=16, CHUNK=4, A=0x0000, B=0x0005, C=0: S=0x0005 and Carry=0, with out_valid 4 cycles after accept.
REQ-034 A=0xFFFF, B=0x0001, C=0: S=0x0000 and Carry=1. With the macro: A=0x7FFF, B=0x0001: Overflow=1 and Carry=0.
REQ-035 Hold out_ready=0 for 5 cycles after out_valid with A and B toggling: S, Carry and in_ready=0 stay stable. Then assert out_ready: IDLE on the next edge.
REQ-036 Assert rst in the 2nd BUSY cycle: all outputs reset at once, no out_valid. After release, accept 0x1234+0x1111, C=1: S=0x2346.
REQ-037 Back-to-back in_valid=1 with out_ready=1: operations accepted every NCHUNK+2 cycles. Random sweep at WIDTH=8, CHUNK=8 (NCHUNK=1) matches the reference sum.
